// File: rtl/p3_5_dec.sv
// ---------------------------------------------------------------------------
// p3_5_dec -- observer / decoder for the output stream of the p3_5 Mealy FSM.
//
// The transmitter p3_5 has three states (A, B, C), one input x and two
// outputs (y, z). This block watches the sampled (y, z) pairs and keeps the
// set of states the transmitter may currently be in. From that set and each
// new pair it recovers x whenever every legal explanation of the pair agrees
// on x. It flags pairs that no candidate state can produce.
//
// Transmitter transitions (state, yz -> x, next state):
//   A : yz=11 -> (1, C)      yz=01 -> (0, B)
//   B : yz=10 -> (0, B) and (1, C)
//   C : yz=01 -> (1, C)      yz=10 -> (0, A)
//   any other (state, yz) pair cannot occur.
//
// Ports:
//   clk      in   1      rising-edge clock (shared with the transmitter)
//   rst      in   1      synchronous, active-high reset; has priority over vld
//   vld      in   1      y/z hold a valid sample this cycle (one per cycle)
//   y, z     in   1      transmitter outputs
//   x_out    out  1      recovered x, meaningful only while x_vld=1
//   x_vld    out  1      x_out is uniquely determined for the last sample
//   err      out  1      one-cycle pulse: last sample fits no candidate state
//   locked   out  1      candidate set holds exactly one state
//   st_set   out  3      candidate set, bit 2:C, bit 1:B, bit 0:A
//   err_cnt  out  CNT_W  saturating count of err pulses
//
// Every output except locked comes from a register, so a sample taken at one
// rising edge shows up on the outputs right after that edge.
// ---------------------------------------------------------------------------
module p3_5_dec #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             y,
  input  logic             z,
  output logic             x_out,
  output logic             x_vld,
  output logic             err,
  output logic             locked,
  output logic [2:0]       st_set,
  output logic [CNT_W-1:0] err_cnt
);

  // One-hot encodings of the transmitter states inside the candidate set.
  localparam logic [2:0] ST_A   = 3'b001;
  localparam logic [2:0] ST_B   = 3'b010;
  localparam logic [2:0] ST_C   = 3'b100;
  localparam logic [2:0] ST_NONE = 3'b000;
  localparam logic [2:0] ST_ALL = 3'b111;

  // x-set encoding: bit 0 means "x=0 is possible", bit 1 "x=1 is possible".
  localparam logic [1:0] X_NONE = 2'b00;
  localparam logic [1:0] X_0    = 2'b01;
  localparam logic [1:0] X_1    = 2'b10;
  localparam logic [1:0] X_BOTH = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [2:0]       st_set_q,  st_set_d;
  logic             x_out_q,   x_out_d;
  logic             x_vld_q,   x_vld_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [1:0] yz;
  assign yz = {y, z};

  // -------------------------------------------------------------------------
  // Per-state candidate tables. Each block answers: if the transmitter were
  // in this state, which next states and which x values explain yz?
  // -------------------------------------------------------------------------
  logic [2:0] a_next, b_next, c_next;
  logic [1:0] a_x,    b_x,    c_x;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    a_next = ST_NONE;
    a_x    = X_NONE;
    unique case (yz)
      2'b11: begin a_next = ST_C; a_x = X_1; end
      2'b01: begin a_next = ST_B; a_x = X_0; end
      default: ;
    endcase
  end

  always_comb begin
    b_next = ST_NONE;
    b_x    = X_NONE;
    // B is the only state with two legal branches for the same output pair,
    // which is what makes x ambiguous and the candidate set grow.
    if (yz == 2'b10) begin
      b_next = ST_B | ST_C;
      b_x    = X_BOTH;
    end
  end

  always_comb begin
    c_next = ST_NONE;
    c_x    = X_NONE;
    unique case (yz)
      2'b01: begin c_next = ST_C; c_x = X_1; end
      2'b10: begin c_next = ST_A; c_x = X_0; end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Union over the current candidates only.
  // -------------------------------------------------------------------------
  logic [2:0] n_set;
  logic [1:0] x_set;
  logic       x_unique;
  logic       cnt_sat;

  assign n_set = ({3{st_set_q[0]}} & a_next)
               | ({3{st_set_q[1]}} & b_next)
               | ({3{st_set_q[2]}} & c_next);

  assign x_set = ({2{st_set_q[0]}} & a_x)
               | ({2{st_set_q[1]}} & b_x)
               | ({2{st_set_q[2]}} & c_x);

  // Exactly one of the two x values survives.
  assign x_unique = ^x_set;
  assign cnt_sat  = (err_cnt_q == CNT_MAX);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    st_set_d  = st_set_q;
    x_out_d   = x_out_q;
    x_vld_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (vld) begin
      if (n_set != ST_NONE) begin
        st_set_d = n_set;
        x_vld_d  = x_unique;
        x_out_d  = x_unique & x_set[1];
      end else begin
        // Nothing explains the pair: assume the link slipped and restart
        // tracking from "any state is possible".
        st_set_d = ST_ALL;
        x_out_d  = 1'b0;
        err_d    = 1'b1;
        if (!cnt_sat) err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_set_q  <= ST_A;
      x_out_q   <= 1'b0;
      x_vld_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      st_set_q  <= st_set_d;
      x_out_q   <= x_out_d;
      x_vld_q   <= x_vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign st_set  = st_set_q;
  assign x_out   = x_out_q;
  assign x_vld   = x_vld_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

  // One-hot test: non-zero and clearing the lowest set bit leaves zero.
  assign locked  = (st_set_q != ST_NONE) && ((st_set_q & (st_set_q - 3'd1)) == ST_NONE);

endmodule

// File: tb/tb_p3_5_dec.sv
// ---------------------------------------------------------------------------
// tb_p3_5_dec -- directed, table-driven bench for p3_5_dec.
//
// Two instances share all inputs: dut (CNT_W=8) and dut_s (CNT_W=2), so one
// stream exercises both the wide counter and early saturation. Each table
// row holds the inputs for one clock and the hand-derived outputs seen just
// after that clock edge.
// ---------------------------------------------------------------------------
module tb_p3_5_dec;

  logic clk;
  logic rst, vld, y, z;

  logic       x_out, x_vld, err, locked;
  logic [2:0] st_set;
  logic [7:0] err_cnt;

  logic       x_out_s, x_vld_s, err_s, locked_s;
  logic [2:0] st_set_s;
  logic [1:0] err_cnt_s;

  p3_5_dec #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vld(vld), .y(y), .z(z),
    .x_out(x_out), .x_vld(x_vld), .err(err), .locked(locked),
    .st_set(st_set), .err_cnt(err_cnt)
  );

  p3_5_dec #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .vld(vld), .y(y), .z(z),
    .x_out(x_out_s), .x_vld(x_vld_s), .err(err_s), .locked(locked_s),
    .st_set(st_set_s), .err_cnt(err_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       r, v, yy, zz;
    bit [2:0] st;
    bit       xv, xo, er, lk;
    int       cnt, cnt_s;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit r, v, yy, zz, input bit [2:0] st,
                     input bit xv, xo, er, lk, input int cnt, cnt_s);
    vec_t t;
    t.r = r; t.v = v; t.yy = yy; t.zz = zz; t.st = st;
    t.xv = xv; t.xo = xo; t.er = er; t.lk = lk; t.cnt = cnt; t.cnt_s = cnt_s;
    vecs.push_back(t);
  endtask

  task automatic drive(input bit r, v, yy, zz);
    rst = r; vld = v; y = yy; z = zz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; y = 1'b0; z = 1'b0;

    //   r  v  y  z  st      xv xo er lk cnt cnt_s
    add(1, 0, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0);  //  0 reset state
    add(0, 1, 1, 1, 3'b100, 1, 1, 0, 1, 0, 0);  //  1 A,11 -> C x=1
    add(1, 0, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0);  //  2 reset clears x_out
    add(0, 1, 0, 1, 3'b010, 1, 0, 0, 1, 0, 0);  //  3 A,01 -> B x=0
    add(0, 1, 1, 0, 3'b110, 0, 0, 0, 0, 0, 0);  //  4 B,10 -> {B,C} ambiguous
    add(0, 1, 0, 1, 3'b100, 1, 1, 0, 1, 0, 0);  //  5 only C fits 01 -> C x=1
    add(0, 1, 1, 0, 3'b001, 1, 0, 0, 1, 0, 0);  //  6 C,10 -> A x=0
    add(0, 1, 0, 1, 3'b010, 1, 0, 0, 1, 0, 0);  //  7
    add(0, 1, 1, 0, 3'b110, 0, 0, 0, 0, 0, 0);  //  8 set 110
    add(0, 1, 1, 0, 3'b111, 0, 0, 0, 0, 0, 0);  //  9 {B,C},10 -> all states
    add(0, 1, 1, 1, 3'b100, 1, 1, 0, 1, 0, 0);  // 10 only A fits 11
    add(0, 1, 1, 0, 3'b001, 1, 0, 0, 1, 0, 0);  // 11 back at A
    add(0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 1, 1);  // 12 A,00 -> err, resync
    add(0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1, 1);  // 13 idle: pulse ends
    add(0, 0, 1, 1, 3'b111, 0, 0, 0, 0, 1, 1);  // 14 idle, junk yz
    add(0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 1, 1);  // 15
    add(0, 0, 1, 0, 3'b111, 0, 0, 0, 0, 1, 1);  // 16
    add(0, 1, 1, 1, 3'b100, 1, 1, 0, 1, 1, 1);  // 17 x_out=1
    add(0, 0, 0, 0, 3'b100, 0, 1, 0, 1, 1, 1);  // 18 idle: x_out holds
    add(0, 1, 1, 0, 3'b001, 1, 0, 0, 1, 1, 1);  // 19
    add(0, 1, 0, 1, 3'b010, 1, 0, 0, 1, 1, 1);  // 20
    add(0, 1, 1, 0, 3'b110, 0, 0, 0, 0, 1, 1);  // 21 set 110, mid-stream
    add(1, 1, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0);  // 22 rst beats vld+bad yz
    add(0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 1, 1);  // 23 five back-to-back errs
    add(0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 2, 2);  // 24
    add(0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 3, 3);  // 25
    add(0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 4, 3);  // 26 2-bit counter saturates
    add(0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 5, 3);  // 27
    add(0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 5, 3);  // 28 idle
    add(0, 1, 1, 1, 3'b100, 1, 1, 0, 1, 5, 3);  // 29 all,11 -> C
    add(0, 1, 1, 1, 3'b111, 0, 0, 1, 0, 6, 3);  // 30 C,11 illegal
    add(0, 1, 0, 1, 3'b110, 0, 0, 0, 0, 6, 3);  // 31 all,01 -> {B,C}, x both
    add(0, 1, 0, 1, 3'b100, 1, 1, 0, 1, 6, 3);  // 32 {B,C},01 -> C x=1

    // Hold reset across the first edge so row 0 sees the reset state.
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].yy, vecs[i].zz);
      check("st_set",    i, int'(st_set),    int'(vecs[i].st));
      check("x_vld",     i, int'(x_vld),     int'(vecs[i].xv));
      check("x_out",     i, int'(x_out),     int'(vecs[i].xo));
      check("err",       i, int'(err),       int'(vecs[i].er));
      check("locked",    i, int'(locked),    int'(vecs[i].lk));
      check("err_cnt",   i, int'(err_cnt),   vecs[i].cnt);
      check("err_cnt_s", i, int'(err_cnt_s), vecs[i].cnt_s);
    end

    // 8-bit counter saturation: 6 + 260 errors must stop at 255, with err
    // staying high on every one of the back-to-back illegal samples.
    begin
      int err_low = 0;
      for (int k = 0; k < 260; k++) begin
        drive(0, 1, 0, 0);
        if (err !== 1'b1) err_low++;
      end
      check("sat_err_pulses", 1000, err_low, 0);
      check("sat_err_cnt",    1000, int'(err_cnt),   255);
      check("sat_err_cnt_s",  1000, int'(err_cnt_s), 3);
      check("sat_st_set",     1000, int'(st_set),    7);
    end

    // Recovery after saturation: a legal sample clears err, count holds.
    drive(0, 1, 1, 1);
    check("post_sat_err",     1001, int'(err),     0);
    check("post_sat_st_set",  1001, int'(st_set),  4);
    check("post_sat_err_cnt", 1001, int'(err_cnt), 255);

    // Reset returns the saturated counters to zero.
    drive(1, 0, 0, 0);
    check("rst_err_cnt",   1002, int'(err_cnt),   0);
    check("rst_err_cnt_s", 1002, int'(err_cnt_s), 0);
    check("rst_locked",    1002, int'(locked),    1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
